// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags
// and sticky overflow/underflow. Define FIFO_FWFT_EN for first-word-fall-through mode.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_enb,
    input  logic                    read_enb,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    clear_err,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AFULL  = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0] C_AEMPTY = (AW+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [AW:0]           w_count_next;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign w_wr_ok      = write_enb && (!r_full || read_enb);
    assign w_rd_ok      = read_enb && !r_empty;
    assign w_count_next = r_count + {{AW{1'b0}}, w_wr_ok} - {{AW{1'b0}}, w_rd_ok};

`ifdef FIFO_FWFT_EN
    // Output stage holds the head word; r_count includes it, so the RAM holds r_count - valid.
    logic        r_out_valid;
    logic [AW:0] w_mem_count;
    logic        w_load;
    logic        w_bypass;
    logic        w_mem_pop;
    logic        w_mem_push;

    // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_mem_count = r_count - {{AW{1'b0}}, r_out_valid};
        w_load      = !r_out_valid || w_rd_ok;
        w_mem_pop   = w_load && (w_mem_count != '0);
        w_bypass    = w_load && (w_mem_count == '0) && w_wr_ok;
        w_mem_push  = w_wr_ok && !w_bypass;
    end
`else
    logic w_mem_pop;
    logic w_mem_push;

    assign w_mem_pop  = w_rd_ok;
    assign w_mem_push = w_wr_ok;
`endif

    // NOTE: storage RAM has no reset; validity is tracked by pointers and count alone.
    always_ff @(posedge clock) begin
        if (w_mem_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifdef FIFO_FWFT_EN
            r_out_valid <= 1'b0;
`endif
        end else begin
            if (w_mem_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_mem_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
`ifdef FIFO_FWFT_EN
            if (w_mem_pop) begin
                r_data_out <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                r_data_out <= data_in;
            end
            if (w_load) begin
                r_out_valid <= w_mem_pop || w_bypass;
            end
`else
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
`endif
            r_count     <= w_count_next;
            r_full      <= (w_count_next == C_DEPTH);
            r_empty     <= (w_count_next == '0);
            r_afull     <= (w_count_next >= C_AFULL);
            r_aempty    <= (w_count_next <= C_AEMPTY);
            // A fresh error in the clear cycle takes priority over the clear.
            r_overflow  <= (r_overflow && !clear_err) || (write_enb && r_full && !read_enb);
            r_underflow <= (r_underflow && !clear_err) || (read_enb && r_empty);
        end
    end

    assign data_out     = r_data_out;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=4, 8-bit); queue model plus read-data scoreboard.
// Define FIFO_FWFT_EN for both bench and RTL to exercise first-word-fall-through mode.
module tb_sync_fifo_param;
    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 3;
    localparam int AEMPTY = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write_enb = 1'b0;
    logic          read_enb = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    sync_fifo_param #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL),
        .AEMPTY_THRESH (AEMPTY)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enb    (write_enb),
        .read_enb     (read_enb),
        .data_in      (data_in),
        .clear_err    (clear_err),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mq[$];     // FIFO contents model
    logic [DW-1:0] sb_q[$];   // expected data_out values, in order
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".count"},        32'(count),        32'(sz));
        check({tag, ".full"},         32'(full),         32'(sz == DEPTH));
        check({tag, ".empty"},        32'(empty),        32'(sz == 0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AFULL));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AEMPTY));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(m_udf));
        check({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    endtask

    // Drive one cycle of stimulus, update the model, then compare just after the edge.
    task automatic step(input string tag, input logic we, input logic re,
                        input logic [DW-1:0] din, input logic clr);
        logic m_full, m_empty, wr_ok, rd_ok;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        wr_ok   = we && (!m_full || re);
        rd_ok   = re && !m_empty;
        write_enb = we;
        read_enb  = re;
        data_in   = din;
        clear_err = clr;
        m_ovf = (m_ovf && !clr) || (we && m_full && !re);
        m_udf = (m_udf && !clr) || (re && m_empty);
`ifdef FIFO_FWFT_EN
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(din);
        if (mq.size() != 0) sb_q.push_back(mq[0]);
`else
        if (rd_ok) sb_q.push_back(mq.pop_front());
        if (wr_ok) mq.push_back(din);
`endif
        @(posedge clock);
        #1;
        if (sb_q.size() != 0) m_dout = sb_q.pop_front();
        check_all(tag);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        clear_err = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        sb_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    logic [DW-1:0] wr_seq [4] = '{8'h24, 8'h81, 8'h09, 8'h63};

    initial begin
        // Reset state
        do_reset(2);
        check_all("reset");
        check("reset.data_out_zero", 32'(data_out), 32'h0);

`ifdef FIFO_FWFT_EN
        step("fwft_wr", 1'b1, 1'b0, 8'h24, 1'b0);
        check("fwft.head_no_read", 32'(data_out), 32'h24);
        do_reset(1);
        check_all("fwft_reset");
`endif

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            step($sformatf("fill%0d", i), 1'b1, 1'b0, wr_seq[i], 1'b0);
            if (i == 1) check("fill.aempty_drop", 32'(almost_empty), 32'h0);
            if (i == 2) check("fill.afull_rise", 32'(almost_full), 32'h1);
        end
        check("fill.full", 32'(full), 32'h1);

        // Overflow, then clear
        step("ovf", 1'b1, 1'b0, 8'hAA, 1'b0);
        check("ovf.flag", 32'(overflow), 32'h1);
        step("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);

        // Drain, then underflow with held data
        for (int i = 0; i < 4; i++) begin
            step($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00, 1'b0);
`ifndef FIFO_FWFT_EN
            check($sformatf("drain%0d.sb", i), 32'(data_out), 32'(wr_seq[i]));
`endif
        end
        step("udf", 1'b0, 1'b1, 8'h00, 1'b0);
        check("udf.flag", 32'(underflow), 32'h1);
`ifndef FIFO_FWFT_EN
        check("udf.hold", 32'(data_out), 32'h63);
`endif

        // Read+write on empty, then streaming read+write
        step("rw_empty", 1'b1, 1'b1, 8'h0D, 1'b0);
        check("rw_empty.count", 32'(count), 32'h1);
        step("rw1", 1'b1, 1'b1, 8'h8D, 1'b0);
        step("rw2", 1'b1, 1'b1, 8'h65, 1'b0);
        step("rw3", 1'b1, 1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("refill%0d", i), 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        step("rw_full", 1'b1, 1'b1, 8'h55, 1'b0);
        check("rw_full.count", 32'(count), 32'h4);
        check("rw_full.no_ovf", 32'(overflow), 32'h0);

        // New error in the clear_err cycle must win
        step("clr_new_err", 1'b1, 1'b0, 8'h77, 1'b1);
        check("clr_new_err.ovf", 32'(overflow), 32'h1);
        step("clr_only", 1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
        end

        // Mid-operation reset with count=3
        while (mq.size() < 3) step("pre_rst_wr", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
        while (mq.size() > 3) step("pre_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        check("pre_rst.count", 32'(count), 32'h3);
        do_reset(1);
        check_all("mid_reset");
        check("mid_reset.data_out_zero", 32'(data_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
